calc_op_sequencer: RTL and testbench

//  Operation sequencer for the calculator datapath. Takes digit/operator click pulses from the

---
 rtl/calc_op_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_calc_op_sequencer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_op_sequencer.sv
// Calculator operation sequencer: turns digit/operator clicks into number-memory and ALU
// control pulses, with operator chaining, a per-operand digit limit, ALU timeout and error hold.
module calc_op_sequencer #(
    parameter int unsigned MAX_DIGITS  = 10,
    parameter int unsigned ALU_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       new_digit,
    input  logic [3:0] digit,
    input  logic       new_op,
    input  logic [2:0] op_code,
    input  logic       alu_done,
    input  logic       alu_err,
    output logic       num_clear,
    output logic       digit_wr,
    output logic [3:0] digit_out,
    output logic       save_a,
    output logic       save_b,
    output logic       alu_start,
    output logic [1:0] alu_op,
    output logic       result_ld,
    output logic       busy,
    output logic       error,
    output logic [1:0] err_code
);

    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int unsigned TMO_W = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;

    localparam logic [2:0] OP_EQUALS = 3'd4;
    localparam logic [2:0] OP_CLEAR  = 3'd5;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_ALU  = 2'd1;
    localparam logic [1:0] ERR_TMO  = 2'd2;

    // A_CLR, B_START, CH_SAVE and S_WR are one-cycle steps that emit the trailing pulse
    // of a multi-pulse sequence.
    typedef enum logic [3:0] {
        S_ENTER_A = 4'd0,
        S_A_CLR   = 4'd1,
        S_OP_WAIT = 4'd2,
        S_ENTER_B = 4'd3,
        S_B_START = 4'd4,
        S_EXEC    = 4'd5,
        S_CH_SAVE = 4'd6,
        S_SHOW    = 4'd7,
        S_S_WR    = 4'd8,
        S_ERR     = 4'd9
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] count, count_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
    logic             chain, chain_nxt;
    logic [1:0]       pend_op, pend_op_nxt;
    logic [3:0]       pend_digit, pend_digit_nxt;

    logic       num_clear_nxt, digit_wr_nxt, save_a_nxt, save_b_nxt;
    logic       alu_start_nxt, result_ld_nxt, busy_nxt, error_nxt;
    logic [3:0] digit_out_nxt;
    logic [1:0] alu_op_nxt, err_code_nxt;

    // Input decode: CLEAR beats other ops, any valid op beats a digit in the same cycle.
    logic op_clear, op_arith, op_equals, op_valid, digit_req, digit_ok, tmo_hit, in_entry;

    assign op_clear  = new_op && (op_code == OP_CLEAR);
    assign op_arith  = new_op && !op_code[2];
    assign op_equals = new_op && (op_code == OP_EQUALS);
    assign op_valid  = op_clear || op_arith || op_equals;
    assign digit_req = new_digit && !op_valid;
    assign digit_ok  = digit_req && (count < CNT_W'(MAX_DIGITS));
    assign tmo_hit   = (tmo_cnt == TMO_W'(ALU_TIMEOUT - 1));
    assign in_entry  = (state == S_ENTER_A) || (state == S_OP_WAIT) || (state == S_ENTER_B);

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_ENTER_A;
            count      <= '0;
            tmo_cnt    <= '0;
            chain      <= 1'b0;
            pend_op    <= 2'd0;
            pend_digit <= 4'd0;
            num_clear  <= 1'b0;
            digit_wr   <= 1'b0;
            digit_out  <= 4'd0;
            save_a     <= 1'b0;
            save_b     <= 1'b0;
            alu_start  <= 1'b0;
            alu_op     <= 2'd0;
            result_ld  <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            tmo_cnt    <= tmo_cnt_nxt;
            chain      <= chain_nxt;
            pend_op    <= pend_op_nxt;
            pend_digit <= pend_digit_nxt;
            num_clear  <= num_clear_nxt;
            digit_wr   <= digit_wr_nxt;
            digit_out  <= digit_out_nxt;
            save_a     <= save_a_nxt;
            save_b     <= save_b_nxt;
            alu_start  <= alu_start_nxt;
            alu_op     <= alu_op_nxt;
            result_ld  <= result_ld_nxt;
            busy       <= busy_nxt;
            error      <= error_nxt;
            err_code   <= err_code_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (op_clear) begin
            state_nxt = S_ENTER_A;
        end else begin
            case (state)
                S_ENTER_A: if (op_arith) state_nxt = S_A_CLR;
                S_A_CLR:   state_nxt = S_OP_WAIT;
                S_OP_WAIT: if (digit_ok) state_nxt = S_ENTER_B;
                S_ENTER_B: if (op_arith || op_equals) state_nxt = S_B_START;
                S_B_START: state_nxt = S_EXEC;
                S_EXEC: begin
                    // A done arriving on the timeout cycle still wins.
                    if (alu_done) begin
                        if (alu_err)    state_nxt = S_ERR;
                        else if (chain) state_nxt = S_CH_SAVE;
                        else            state_nxt = S_SHOW;
                    end else if (tmo_hit) begin
                        state_nxt = S_ERR;
                    end
                end
                S_CH_SAVE: state_nxt = S_A_CLR;
                S_SHOW: begin
                    if (op_arith)       state_nxt = S_A_CLR;
                    else if (digit_req) state_nxt = S_S_WR;
                end
                S_S_WR:    state_nxt = S_ENTER_A;
                S_ERR:     state_nxt = S_ERR;
                default:   state_nxt = S_ENTER_A;
            endcase
        end
    end

    // Output and datapath next values
    always_comb begin
        num_clear_nxt  = 1'b0;
        digit_wr_nxt   = 1'b0;
        save_a_nxt     = 1'b0;
        save_b_nxt     = 1'b0;
        alu_start_nxt  = 1'b0;
        result_ld_nxt  = 1'b0;
        digit_out_nxt  = digit_out;
        alu_op_nxt     = alu_op;
        err_code_nxt   = err_code;
        count_nxt      = count;
        chain_nxt      = chain;
        pend_op_nxt    = pend_op;
        pend_digit_nxt = pend_digit;
        tmo_cnt_nxt    = tmo_cnt;
        busy_nxt       = (state_nxt == S_EXEC);
        error_nxt      = (state_nxt == S_ERR);

        if (op_clear) begin
            num_clear_nxt = 1'b1;
            count_nxt     = '0;
            err_code_nxt  = ERR_NONE;
            chain_nxt     = 1'b0;
        end else if (digit_ok && in_entry) begin
            digit_wr_nxt  = 1'b1;
            digit_out_nxt = digit;
            count_nxt     = count + CNT_W'(1);
        end else begin
            case (state)
                S_ENTER_A, S_SHOW: begin
                    // In SHOW the ALU result already sits in the buffer and becomes A.
                    if (op_arith) begin
                        save_a_nxt = 1'b1;
                        alu_op_nxt = op_code[1:0];
                        count_nxt  = '0;
                    end else if ((state == S_SHOW) && digit_req) begin
                        num_clear_nxt  = 1'b1;
                        pend_digit_nxt = digit;
                    end
                end
                S_A_CLR: num_clear_nxt = 1'b1;
                S_OP_WAIT: if (op_arith) alu_op_nxt = op_code[1:0];
                S_ENTER_B: begin
                    if (op_arith || op_equals) begin
                        save_b_nxt  = 1'b1;
                        chain_nxt   = op_arith;
                        pend_op_nxt = op_code[1:0];
                    end
                end
                S_B_START: begin
                    alu_start_nxt = 1'b1;
                    tmo_cnt_nxt   = '0;
                end
                S_EXEC: begin
                    if (alu_done) begin
                        if (alu_err) err_code_nxt  = ERR_ALU;
                        else         result_ld_nxt = 1'b1;
                    end else if (tmo_hit) begin
                        err_code_nxt = ERR_TMO;
                    end else begin
                        tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
                    end
                end
                S_CH_SAVE: begin
                    save_a_nxt = 1'b1;
                    alu_op_nxt = pend_op;
                    count_nxt  = '0;
                    chain_nxt  = 1'b0;
                end
                S_S_WR: begin
                    digit_wr_nxt  = 1'b1;
                    digit_out_nxt = pend_digit;
                    count_nxt     = CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: directed scenarios plus random click streams checked against
// a click-level model that predicts pulses at fixed offsets after each input.
module tb_calc_op_sequencer;

    localparam logic [5:0] NO  = 6'b000000;
    localparam logic [5:0] CLR = 6'b100000;
    localparam logic [5:0] WR  = 6'b010000;
    localparam logic [5:0] SA  = 6'b001000;
    localparam logic [5:0] SB  = 6'b000100;
    localparam logic [5:0] ST  = 6'b000010;
    localparam logic [5:0] RL  = 6'b000001;

    localparam int M_A = 0, M_OPW = 1, M_B = 2, M_EX = 3, M_SHOW = 4, M_ERR = 5;
    localparam int MAXD = 10;

    logic       clk, reset_n, new_digit, new_op, alu_done, alu_err;
    logic [3:0] digit;
    logic [2:0] op_code;
    logic       num_clear, digit_wr, save_a, save_b, alu_start, result_ld, busy, error;
    logic [3:0] digit_out;
    logic [1:0] alu_op, err_code;
    logic [15:0] all_out;

    int n_total = 0;
    int n_bad   = 0;

    logic [5:0]  obs_p [1:5];
    logic [3:0]  obs_d [1:5];
    logic [29:0] obs_win;
    logic [5:0]  exp_p [1:5];
    logic [3:0]  exp_d [1:5];

    int         m_state, m_cnt, m_exec_ev;
    logic       m_chain;
    logic [1:0] m_op, m_pend, m_err;

    calc_op_sequencer dut (
        .clk(clk), .reset_n(reset_n), .new_digit(new_digit), .digit(digit),
        .new_op(new_op), .op_code(op_code), .alu_done(alu_done), .alu_err(alu_err),
        .num_clear(num_clear), .digit_wr(digit_wr), .digit_out(digit_out),
        .save_a(save_a), .save_b(save_b), .alu_start(alu_start), .alu_op(alu_op),
        .result_ld(result_ld), .busy(busy), .error(error), .err_code(err_code)
    );

    assign all_out = {num_clear, digit_wr, digit_out, save_a, save_b, alu_start,
                      alu_op, result_ld, busy, error, err_code};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One input cycle, then record the pulse pattern of the five following cycles.
    task automatic drive_event(input logic nd, input logic [3:0] d, input logic no,
                               input logic [2:0] oc, input logic dn, input logic er);
        @(negedge clk);
        new_digit = nd; digit = d; new_op = no; op_code = oc; alu_done = dn; alu_err = er;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                new_digit = 1'b0; new_op = 1'b0; alu_done = 1'b0; alu_err = 1'b0;
            end
            obs_p[k] = {num_clear, digit_wr, save_a, save_b, alu_start, result_ld};
            obs_d[k] = digit_out;
        end
        obs_win = {obs_p[1], obs_p[2], obs_p[3], obs_p[4], obs_p[5]};
    endtask

    task automatic dig(input int d);
        drive_event(1'b1, 4'(d), 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic op(input int c);
        drive_event(1'b0, 4'd0, 1'b1, 3'(c), 1'b0, 1'b0);
    endtask

    task automatic done(input logic e);
        drive_event(1'b0, 4'd0, 1'b0, 3'd0, 1'b1, e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Click-level model: spec states only, pulses placed at their T+k offsets.
    task automatic model_step(input logic nd, input logic [3:0] d, input logic no,
                              input logic [2:0] oc, input logic dn, input logic er);
        logic is_clr, is_ar, is_eq, dg;
        is_clr = no && (oc == 3'd5);
        is_ar  = no && (oc < 3'd4);
        is_eq  = no && (oc == 3'd4);
        dg     = nd && !(no && (oc <= 3'd5));
        for (int k = 1; k <= 5; k++) begin
            exp_p[k] = NO;
            exp_d[k] = 4'd0;
        end
        if (is_clr) begin
            exp_p[1] = CLR; m_cnt = 0; m_err = 2'd0; m_state = M_A;
        end else begin
            case (m_state)
                M_A, M_B: begin
                    if (m_state == M_A && is_ar) begin
                        exp_p[1] = SA; exp_p[2] = CLR; m_op = oc[1:0]; m_cnt = 0; m_state = M_OPW;
                    end else if (m_state == M_B && (is_ar || is_eq)) begin
                        exp_p[1] = SB; exp_p[2] = ST; m_chain = is_ar; m_pend = oc[1:0];
                        m_exec_ev = 0; m_state = M_EX;
                    end else if (dg && m_cnt < MAXD) begin
                        exp_p[1] = WR; exp_d[1] = d; m_cnt++;
                    end
                end
                M_OPW: begin
                    if (is_ar) m_op = oc[1:0];
                    else if (dg) begin
                        exp_p[1] = WR; exp_d[1] = d; m_cnt = 1; m_state = M_B;
                    end
                end
                M_EX: begin
                    if (dn && er) begin
                        m_err = 2'd1; m_state = M_ERR;
                    end else if (dn) begin
                        exp_p[1] = RL;
                        if (m_chain) begin
                            exp_p[2] = SA; exp_p[3] = CLR; m_op = m_pend; m_cnt = 0; m_state = M_OPW;
                        end else begin
                            m_state = M_SHOW;
                        end
                    end else begin
                        m_exec_ev++;
                    end
                end
                M_SHOW: begin
                    if (is_ar) begin
                        exp_p[1] = SA; exp_p[2] = CLR; m_op = oc[1:0]; m_cnt = 0; m_state = M_OPW;
                    end else if (dg) begin
                        exp_p[1] = CLR; exp_p[2] = WR; exp_d[2] = d; m_cnt = 1; m_state = M_A;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1; new_digit = 1'b0; new_op = 1'b0; alu_done = 1'b0; alu_err = 1'b0;
        digit = 4'd0; op_code = 3'd0;
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if (all_out !== 16'h0) begin n_bad++; $display("FAIL reset_hold got=%h want=0", all_out); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if (all_out !== 16'h0) begin n_bad++; $display("FAIL reset_idle got=%h want=0", all_out); end
    endtask

    task automatic test_basic_add();
        dig(1);
        n_total++;
        if (obs_win !== {WR, NO, NO, NO, NO} || obs_d[1] !== 4'd1) begin
            n_bad++; $display("FAIL add_d1 got=%h/%0d want=%h/1", obs_win, obs_d[1], {WR, NO, NO, NO, NO});
        end
        dig(2);
        n_total++;
        if (obs_win !== {WR, NO, NO, NO, NO} || obs_d[1] !== 4'd2) begin
            n_bad++; $display("FAIL add_d2 got=%h/%0d want=%h/2", obs_win, obs_d[1], {WR, NO, NO, NO, NO});
        end
        op(0);
        n_total++;
        if (obs_win !== {SA, CLR, NO, NO, NO}) begin
            n_bad++; $display("FAIL add_op got=%h want=%h", obs_win, {SA, CLR, NO, NO, NO});
        end
        dig(3);
        n_total++;
        if (obs_win !== {WR, NO, NO, NO, NO} || obs_d[1] !== 4'd3) begin
            n_bad++; $display("FAIL add_d3 got=%h/%0d want=%h/3", obs_win, obs_d[1], {WR, NO, NO, NO, NO});
        end
        op(4);
        n_total++;
        if (obs_win !== {SB, ST, NO, NO, NO} || {busy, alu_op} !== 3'b100) begin
            n_bad++; $display("FAIL add_eq got=%h busy/op=%b want=%h 100", obs_win, {busy, alu_op}, {SB, ST, NO, NO, NO});
        end
        done(1'b0);
        n_total++;
        if (obs_win !== {RL, NO, NO, NO, NO} || {busy, error} !== 2'b00) begin
            n_bad++; $display("FAIL add_done got=%h busy/err=%b want=%h 00", obs_win, {busy, error}, {RL, NO, NO, NO, NO});
        end
        dig(7);
        n_total++;
        if (obs_win !== {CLR, WR, NO, NO, NO} || obs_d[2] !== 4'd7) begin
            n_bad++; $display("FAIL show_digit got=%h/%0d want=%h/7", obs_win, obs_d[2], {CLR, WR, NO, NO, NO});
        end
    endtask

    task automatic test_digit_limit();
        int wr_seen;
        op(5);
        n_total++;
        if (obs_win !== {CLR, NO, NO, NO, NO}) begin
            n_bad++; $display("FAIL lim_clear got=%h want=%h", obs_win, {CLR, NO, NO, NO, NO});
        end
        wr_seen = 0;
        for (int i = 0; i < 11; i++) begin
            dig(i % 10);
            for (int k = 1; k <= 5; k++) wr_seen += int'(obs_p[k][4]);
        end
        n_total++;
        if (wr_seen != 10) begin n_bad++; $display("FAIL lim_count got=%0d want=10", wr_seen); end
        n_total++;
        if (obs_win !== 30'h0) begin n_bad++; $display("FAIL lim_11th got=%h want=0", obs_win); end
    endtask

    task automatic test_chain();
        op(5); dig(5); op(2); dig(2);
        op(1);
        n_total++;
        if (obs_win !== {SB, ST, NO, NO, NO} || {busy, alu_op} !== 3'b110) begin
            n_bad++; $display("FAIL chain_op got=%h busy/op=%b want=%h 110", obs_win, {busy, alu_op}, {SB, ST, NO, NO, NO});
        end
        done(1'b0);
        n_total++;
        if (obs_win !== {RL, SA, CLR, NO, NO} || {busy, alu_op} !== 3'b001) begin
            n_bad++; $display("FAIL chain_done got=%h busy/op=%b want=%h 001", obs_win, {busy, alu_op}, {RL, SA, CLR, NO, NO});
        end
        dig(1);
        n_total++;
        if (obs_win !== {WR, NO, NO, NO, NO}) begin
            n_bad++; $display("FAIL chain_opwait got=%h want=%h", obs_win, {WR, NO, NO, NO, NO});
        end
        op(4);
        n_total++;
        if (obs_win !== {SB, ST, NO, NO, NO} || {busy, alu_op} !== 3'b101) begin
            n_bad++; $display("FAIL chain_eq got=%h busy/op=%b want=%h 101", obs_win, {busy, alu_op}, {SB, ST, NO, NO, NO});
        end
        done(1'b0);
    endtask

    task automatic test_div_err();
        op(5); dig(8); op(3); dig(0); op(4);
        done(1'b1);
        n_total++;
        if (obs_win !== 30'h0 || {busy, error, err_code} !== 4'b0101) begin
            n_bad++; $display("FAIL err_done got=%h status=%b want=0 0101", obs_win, {busy, error, err_code});
        end
        dig(4);
        op(0);
        n_total++;
        if (obs_win !== 30'h0 || {error, err_code} !== 3'b101) begin
            n_bad++; $display("FAIL err_hold got=%h status=%b want=0 101", obs_win, {error, err_code});
        end
        op(5);
        n_total++;
        if (obs_win !== {CLR, NO, NO, NO, NO} || {error, err_code} !== 3'b000) begin
            n_bad++; $display("FAIL err_clear got=%h status=%b want=%h 000", obs_win, {error, err_code}, {CLR, NO, NO, NO, NO});
        end
    endtask

    // alu_start is registered on edge P; edges P+1..P+1024 may still carry a done.
    task automatic test_timeout(input logic late_done);
        op(5); dig(1); op(0); dig(2); op(4);
        repeat (1020) @(negedge clk);
        n_total++;
        if ({busy, error} !== 2'b10) begin
            n_bad++; $display("FAIL tmo_before got=%b want=10", {busy, error});
        end
        if (late_done) begin
            alu_done = 1'b1;
            @(negedge clk);
            alu_done = 1'b0;
            n_total++;
            if ({result_ld, busy, error, err_code} !== 5'b10000) begin
                n_bad++; $display("FAIL tmo_edge_done got=%b want=10000", {result_ld, busy, error, err_code});
            end
        end else begin
            @(negedge clk);
            n_total++;
            if ({busy, error, err_code} !== 4'b0110) begin
                n_bad++; $display("FAIL tmo_fire got=%b want=0110", {busy, error, err_code});
            end
            done(1'b0);
            n_total++;
            if (obs_win !== 30'h0 || {error, err_code} !== 3'b110) begin
                n_bad++; $display("FAIL tmo_late got=%h status=%b want=0 110", obs_win, {error, err_code});
            end
        end
    endtask

    task automatic test_clear_in_exec();
        op(5); dig(1); op(0); dig(2); op(4);
        drive_event(1'b1, 4'd6, 1'b1, 3'd5, 1'b0, 1'b0);
        n_total++;
        if (obs_win !== {CLR, NO, NO, NO, NO} || {busy, error} !== 2'b00) begin
            n_bad++; $display("FAIL exec_clear got=%h busy/err=%b want=%h 00", obs_win, {busy, error}, {CLR, NO, NO, NO, NO});
        end
        done(1'b0);
        n_total++;
        if (obs_win !== 30'h0) begin n_bad++; $display("FAIL exec_late_done got=%h want=0", obs_win); end
        dig(3);
        n_total++;
        if (obs_win !== {WR, NO, NO, NO, NO}) begin
            n_bad++; $display("FAIL exec_after_clear got=%h want=%h", obs_win, {WR, NO, NO, NO, NO});
        end
    endtask

    task automatic test_async_reset();
        op(5); dig(3); op(2); dig(4); op(4);
        n_total++;
        if ({busy, alu_op} !== 3'b110) begin
            n_bad++; $display("FAIL arst_pre got=%b want=110", {busy, alu_op});
        end
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if (all_out !== 16'h0) begin n_bad++; $display("FAIL arst_async got=%h want=0", all_out); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        dig(5);
        n_total++;
        if (obs_win !== {WR, NO, NO, NO, NO} || alu_op !== 2'd0) begin
            n_bad++; $display("FAIL arst_after got=%h op=%0d want=%h 0", obs_win, alu_op, {WR, NO, NO, NO, NO});
        end
    endtask

    task automatic test_random(input int n_ev);
        logic nd, no, dn, er;
        logic [3:0] d;
        logic [2:0] oc;
        int r;
        do_reset();
        m_state = M_A; m_cnt = 0; m_exec_ev = 0; m_chain = 1'b0;
        m_op = 2'd0; m_pend = 2'd0; m_err = 2'd0;
        for (int i = 0; i < n_ev; i++) begin
            r = $urandom_range(0, 99);
            nd = 1'b0; no = 1'b0; dn = 1'b0; er = 1'b0;
            d = 4'($urandom_range(0, 9));
            oc = 3'($urandom_range(0, 4));
            if (m_state == M_EX && (m_exec_ev >= 3 || r < 50)) begin
                dn = 1'b1; er = ($urandom_range(0, 9) == 0);
            end else if (r < 50) nd = 1'b1;
            else if (r < 88) no = 1'b1;
            else if (r < 93) begin no = 1'b1; oc = 3'd5; end
            else if (r < 96) begin no = 1'b1; oc = 3'($urandom_range(6, 7)); end
            else begin dn = 1'b1; er = 1'($urandom_range(0, 1)); end
            model_step(nd, d, no, oc, dn, er);
            drive_event(nd, d, no, oc, dn, er);
            for (int k = 1; k <= 5; k++) begin
                n_total++;
                if (obs_p[k] !== exp_p[k]) begin
                    n_bad++; $display("FAIL rand ev%0d T+%0d pulses got=%b want=%b", i, k, obs_p[k], exp_p[k]);
                end
                if (exp_p[k][4]) begin
                    n_total++;
                    if (obs_d[k] !== exp_d[k]) begin
                        n_bad++; $display("FAIL rand ev%0d T+%0d digit got=%0d want=%0d", i, k, obs_d[k], exp_d[k]);
                    end
                end
            end
            n_total++;
            if ({busy, error, err_code, alu_op} !== {m_state == M_EX, m_state == M_ERR, m_err, m_op}) begin
                n_bad++; $display("FAIL rand ev%0d status got=%b want=%b", i, {busy, error, err_code, alu_op},
                                  {m_state == M_EX, m_state == M_ERR, m_err, m_op});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_digit_limit();
        test_chain();
        test_div_err();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_clear_in_exec();
        test_async_reset();
        test_random(400);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
